// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge and MAC stages.
package systolic_pkg;

    // Operand width shared between the feeders and the MACs.
    localparam int unsigned FEEDER_DATA_WIDTH = 32;

    // Operand feeder control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SKEW   = 3'd1,
        ST_STREAM = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/feeder_buffer.sv
// Operand register file: synchronous write, combinational read, no reset.
module feeder_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FEEDER_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/operand_feeder.sv
// Edge feeder: buffers one operand vector, then streams it into the edge MAC
// with a lane skew before the first beat and a hold window after each beat.
module operand_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = FEEDER_DATA_WIDTH,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SKEW        = 0,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic [CW-1:0]         k_len,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_waiting,
    output logic                  out_finished,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = (SKEW > 0) ? $clog2(SKEW + 1) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    feeder_state_t         r_state;
    feeder_state_t         w_state_nxt;
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         w_wr_ptr_nxt;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         r_k_len;
    logic [CW-1:0]         w_k_len_nxt;
    logic [SW-1:0]         r_skew_cnt;
    logic [SW-1:0]         w_skew_cnt_nxt;
    logic [HW-1:0]         r_hold_cnt;
    logic [HW-1:0]         w_hold_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic                  r_done;
    logic                  w_done_nxt;

    logic                  w_wr_en;
    logic                  w_load_ready;
    logic                  w_start_ok;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Pointers never exceed DEPTH; the buffer is only addressed below DEPTH.
    assign w_wr_addr    = AW'(r_wr_ptr);
    assign w_rd_addr    = (r_state == ST_IDLE) ? '0 : AW'(r_rd_ptr);
    assign w_load_ready = (r_state == ST_IDLE) && (r_wr_ptr < CW'(DEPTH));
    // Start is qualified against the pre-write fill level.
    assign w_start_ok   = start && (k_len != '0) && (k_len <= r_wr_ptr);

    feeder_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_buffer (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (load_data),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (w_rd_data)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_k_len    <= '0;
            r_skew_cnt <= '0;
            r_hold_cnt <= '0;
            r_out_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_k_len    <= w_k_len_nxt;
            r_skew_cnt <= w_skew_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_out_data <= w_out_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and register-update decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_k_len_nxt    = r_k_len;
        w_skew_cnt_nxt = r_skew_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_out_data_nxt = r_out_data;
        w_done_nxt     = 1'b0;
        w_wr_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (load_valid && w_load_ready) begin
                    w_wr_en      = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + CW'(1);
                end
                if (w_start_ok) begin
                    w_k_len_nxt    = k_len;
                    w_rd_ptr_nxt   = '0;
                    w_out_data_nxt = w_rd_data;
                    if (SKEW > 0) begin
                        w_skew_cnt_nxt = SW'(SKEW - 1);
                        w_state_nxt    = ST_SKEW;
                    end else begin
                        w_state_nxt    = ST_STREAM;
                    end
                end
            end

            ST_SKEW: begin
                if (r_skew_cnt == '0) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_skew_cnt_nxt = r_skew_cnt - SW'(1);
                end
            end

            ST_STREAM: begin
                if (out_ready) begin
                    w_rd_ptr_nxt   = r_rd_ptr + CW'(1);
                    w_hold_cnt_nxt = HW'(HOLD_CYCLES);
                    w_state_nxt    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (r_hold_cnt <= HW'(1)) begin
                    if (r_rd_ptr == r_k_len) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_out_data_nxt = w_rd_data;
                        w_state_nxt    = ST_STREAM;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HW'(1);
                end
            end

            ST_FINISH: begin
                if (out_ready) begin
                    w_done_nxt   = 1'b1;
                    w_wr_ptr_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are decoded from the state register only.
    assign load_ready   = w_load_ready;
    assign out_data     = r_out_data;
    assign out_waiting  = (r_state == ST_STREAM);
    assign out_finished = (r_state == ST_FINISH);
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Upstream edge stage of the systolic array.
- Buffers one row (A side) or one column (B side) of operands, then streams them into the edge MAC's input port using the array's waiting/ready/finished handshake.
- Applies a per-lane skew delay before the first operand so the wavefront enters the array diagonally.
- Holds each operand stable long enough for the MAC to accumulate it and pass it on.

Parameters:
- DATA_WIDTH, 32, operand width; matches the MAC data width.
- DEPTH, 8, buffer entries; the maximum vector length K.
- SKEW, 0, idle cycles between start and the first operand offer; set to the lane index.
- HOLD_CYCLES, 2, cycles out_data stays frozen after each accepted beat; covers MAC ACCUM and PASS.
- CW, $clog2(DEPTH+1), width of counters and k_len.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  a write beat is offered on load_data.
- load_data  in  DATA_WIDTH  operand to append to the buffer.
- load_ready  out  1  buffer accepts writes.
- k_len  in  CW  number of operands to stream; sampled when start is accepted.
- start  in  1  single-cycle request to begin streaming.
- out_data  out  DATA_WIDTH  operand to the MAC A_in or B_in.
- out_waiting  out  1  operand offered; drives the MAC *_in_waiting.
- out_finished  out  1  vector exhausted; drives the MAC *_in_finished.
- out_ready  in  1  from the MAC *_in_ready.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the finished handshake completes.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; wr_ptr, rd_ptr, skew and hold counters go to 0.
  - out_data=0; out_waiting=0; out_finished=0; done=0; busy=0.
  - Buffer contents are don't-care.
  - Reset mid-stream aborts immediately with the same values; no finished is emitted.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready to any output.
- IDLE:
  - load_ready = (wr_ptr < DEPTH).
  - When load_valid & load_ready, mem[wr_ptr] <= load_data and wr_ptr increments.
  - When start is high, 1 <= k_len <= wr_ptr: latch k_len, set rd_ptr=0, set out_data <= mem[0]. Go to SKEW if SKEW>0, otherwise to STREAM.
  - start with k_len=0 or k_len>wr_ptr is ignored; state stays IDLE.
  - If load and start occur in the same cycle, the write is performed and start is checked against the pre-write wr_ptr.
- SKEW:
  - load_ready=0.
  - Count down exactly SKEW cycles, then go to STREAM.
  - The first out_waiting rises SKEW+1 cycles after the start edge.
- STREAM:
  - out_waiting=1 and out_data=mem[rd_ptr].
  - A beat transfers at a posedge where out_waiting & out_ready are both high.
  - On transfer: rd_ptr increments, then go to HOLD. The hold counter is HOLD_CYCLES.
- HOLD:
  - out_waiting=0; out_data stays unchanged for HOLD_CYCLES cycles.
  - When the hold expires: if rd_ptr==k_len, go to FINISH. Otherwise set out_data <= mem[rd_ptr] and go to STREAM.
- FINISH:
  - out_finished=1, out_waiting=0.
  - Exit when out_ready is high at a posedge, i.e. the MAC in IN_WAIT has seen finished.
  - On exit: pulse done for 1 cycle, clear wr_ptr to 0 (buffer emptied), go to IDLE.
- out_ready low stalls STREAM and FINISH indefinitely; out_data and the flags stay stable throughout the stall.
- out_waiting and out_finished are never high together.
- start is ignored outside IDLE. Loads are ignored outside IDLE (load_ready=0).
- With k_len=DEPTH, rd_ptr reaches DEPTH, which CW must represent. The pointers never wrap.

Decomposition:
- Shared package systolic_pkg: feeder_state_t enum {IDLE, SKEW, STREAM, HOLD, FINISH}, and DATA_WIDTH default constant shared with the MAC.
- One natural sub-module: feeder_buffer, a DEPTH x DATA_WIDTH register file with synchronous write and combinational read.

Test Plan:
- Load 3,5,7, start k_len=3, SKEW=0, out_ready tied to a MAC model:
  - out_data sequence is 3,5,7, each held HOLD_CYCLES+1 cycles after acceptance.
  - Then out_finished goes high; done pulses once; MAC model C_out=3*x0+5*x1+7*x2.
- SKEW=2, load 1 operand, start: out_waiting rises exactly 3 cycles after the start edge.
- Hold out_ready=0 for 10 cycles mid-stream:
  - out_waiting stays 1 and out_data is unchanged.
  - Exactly one transfer occurs when ready returns.
- Load 4 operands, start with k_len=5: ignored, busy stays 0. Then start with k_len=4: streams 4 operands.
- Load DEPTH=8 operands: load_ready drops after the 8th write and the 9th load is not accepted; k_len=8 streams all 8 operands.
- Assert rst during HOLD after the 2nd beat:
  - Next cycle all outputs are 0 and state is IDLE; no done pulse.
  - A fresh load/start sequence works normally.
